// File: rtl/victim_cache_pkg.sv
// Shared widths, entry layout and helpers for the L1 victim cache.
package victim_cache_pkg;

  localparam int VC_NUM_WAYS    = 8;
  localparam int VC_BLOCK_BYTES = 64;
  localparam int VC_TAG_W       = 44;
  localparam int VC_INDEX_W     = 6;
  localparam int VC_OFFSET_W    = $clog2(VC_BLOCK_BYTES);
  localparam int VC_WAY_W       = $clog2(VC_NUM_WAYS);
  localparam int VC_DATA_W      = VC_BLOCK_BYTES * 8;

  typedef struct packed {
    logic                  valid;
    logic [VC_TAG_W-1:0]   tag;
    logic [VC_INDEX_W-1:0] index;
    logic [VC_DATA_W-1:0]  data;
  } vc_entry_t;

  // Index of the lowest set bit, 0 when none is set (callers qualify with |v).
  function automatic int unsigned vc_first_set(input logic [63:0] v);
    int unsigned r;
    r = 0;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/vc_lru_age.sv
// Per-way age counters forming a permutation of 0..NUM_WAYS-1; age 0 is youngest.
module vc_lru_age #(
  parameter int NUM_WAYS = 8,
  parameter int WAY_W    = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            touch_a,
  input  logic [WAY_W-1:0]                way_a,
  input  logic                            touch_b,
  input  logic [WAY_W-1:0]                way_b,
  output logic [WAY_W-1:0]                lru_way,
  output logic [NUM_WAYS-1:0][WAY_W-1:0]  ages
);

  typedef logic [NUM_WAYS-1:0][WAY_W-1:0] age_vec_t;

  age_vec_t age_q, age_d, age_mid;

  function automatic age_vec_t touch(input age_vec_t a, input logic [WAY_W-1:0] way);
    age_vec_t r;
    r = a;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (a[w] < a[way]) r[w] = a[w] + 1'b1;
    end
    r[way] = '0;
    return r;
  endfunction

  // Hit is applied before insert so a same-cycle insert ends youngest.
  always_comb begin
    age_mid = touch_a ? touch(age_q, way_a) : age_q;
    age_d   = touch_b ? touch(age_mid, way_b) : age_mid;
  end

  always_comb begin
    lru_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (age_q[w] == WAY_W'(NUM_WAYS - 1)) lru_way = WAY_W'(w);
    end
  end

  assign ages = age_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WAYS; w++) age_q[w] <= WAY_W'(w);
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/victim_cache_param.sv
// Fully associative victim cache: two-stage late-tag lookup with exclusive hits,
// LRU replacement and writeback of displaced entries.
module victim_cache_param
  import victim_cache_pkg::*;
#(
  parameter int NUM_WAYS    = VC_NUM_WAYS,
  parameter int BLOCK_BYTES = VC_BLOCK_BYTES,
  parameter int TAG_W       = VC_TAG_W,
  parameter int INDEX_W     = VC_INDEX_W,
  localparam int OFFSET_W   = $clog2(BLOCK_BYTES),
  localparam int WAY_W      = $clog2(NUM_WAYS),
  localparam int DATA_W     = BLOCK_BYTES * 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        lookup_valid,
  output logic                        lookup_ready,
  input  logic [INDEX_W+OFFSET_W-1:0] lookup_addr,
  input  logic [TAG_W-1:0]            phys_tag_ret,
  input  logic                        tlb_miss,
  input  logic                        insert_valid,
  input  logic [TAG_W-1:0]            insert_tag,
  input  logic [INDEX_W-1:0]          insert_index,
  input  logic [DATA_W-1:0]           insert_data,
  output logic                        resp_valid,
  output logic                        resp_hit,
  output logic [7:0]                  resp_byte,
  output logic [DATA_W-1:0]           resp_block,
  output logic [WAY_W-1:0]            resp_way,
  output logic                        evict_valid,
  output logic [TAG_W-1:0]            evict_tag,
  output logic [INDEX_W-1:0]          evict_index,
  output logic [DATA_W-1:0]           evict_data
);

  logic [NUM_WAYS-1:0]              valid_q, valid_d;
  logic [NUM_WAYS-1:0][TAG_W-1:0]   tag_q, tag_d;
  logic [NUM_WAYS-1:0][INDEX_W-1:0] index_q, index_d;
  logic [NUM_WAYS-1:0][DATA_W-1:0]  data_q, data_d;

  logic                s1_valid_q, s1_valid_d;
  logic [INDEX_W-1:0]  s1_index_q, s1_index_d;
  logic [OFFSET_W-1:0] s1_offset_q, s1_offset_d;

  logic                resp_valid_q, resp_valid_d;
  logic                resp_hit_q, resp_hit_d;
  logic [7:0]          resp_byte_q, resp_byte_d;
  logic [DATA_W-1:0]   resp_block_q, resp_block_d;
  logic [WAY_W-1:0]    resp_way_q, resp_way_d;
  logic                evict_valid_q, evict_valid_d;
  logic [TAG_W-1:0]    evict_tag_q, evict_tag_d;
  logic [INDEX_W-1:0]  evict_index_q, evict_index_d;
  logic [DATA_W-1:0]   evict_data_q, evict_data_d;

  logic [NUM_WAYS-1:0] s2_match, ins_match, free_ways;
  logic                s2_go, s2_hit, ins_go, ins_hit;
  logic [WAY_W-1:0]    hit_way, ins_way, lru_way;
  logic                touch_hit;
  // Age view is kept visible for debug; replacement only needs lru_way.
  logic [NUM_WAYS-1:0][WAY_W-1:0] lru_ages_unused;

  assign lookup_ready = !insert_valid && !flush;
  assign free_ways    = ~valid_q;

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    assign s2_match[w]  = valid_q[w] && tag_q[w] == phys_tag_ret && index_q[w] == s1_index_q;
    assign ins_match[w] = valid_q[w] && tag_q[w] == insert_tag && index_q[w] == insert_index;
  end

  vc_lru_age #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) u_lru (
    .clk     (clk),
    .reset   (reset),
    .touch_a (touch_hit),
    .way_a   (hit_way),
    .touch_b (ins_go),
    .way_b   (ins_way),
    .lru_way (lru_way),
    .ages    (lru_ages_unused)
  );

  // Lookup pipeline and insert way selection, all against pre-update array state.
  always_comb begin
    s1_valid_d  = lookup_valid && lookup_ready;
    s1_index_d  = s1_index_q;
    s1_offset_d = s1_offset_q;
    if (s1_valid_d) begin
      s1_index_d  = lookup_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
      s1_offset_d = lookup_addr[OFFSET_W-1:0];
    end

    s2_go     = s1_valid_q && !tlb_miss;
    s2_hit    = |s2_match;
    hit_way   = WAY_W'(vc_first_set(64'(s2_match)));
    touch_hit = s2_go && s2_hit && !flush;

    ins_go  = insert_valid && !flush;
    ins_hit = |ins_match;
    if (ins_hit)         ins_way = WAY_W'(vc_first_set(64'(ins_match)));
    else if (|free_ways) ins_way = WAY_W'(vc_first_set(64'(free_ways)));
    else                 ins_way = lru_way;

    resp_valid_d = s2_go;
    resp_hit_d   = s2_go && s2_hit;
    resp_block_d = resp_hit_d ? data_q[hit_way] : '0;
    resp_byte_d  = resp_block_d[{s1_offset_q, 3'b000} +: 8];
    resp_way_d   = resp_hit_d ? hit_way : '0;

    evict_valid_d = ins_go && !ins_hit && valid_q[ins_way];
    evict_tag_d   = evict_valid_d ? tag_q[ins_way]   : '0;
    evict_index_d = evict_valid_d ? index_q[ins_way] : '0;
    evict_data_d  = evict_valid_d ? data_q[ins_way]  : '0;
  end

  // Insert overrides a same-way hit invalidation; flush overrides everything.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    index_d = index_q;
    data_d  = data_q;
    if (s2_go && s2_hit) valid_d[hit_way] = 1'b0;
    if (ins_go) begin
      valid_d[ins_way] = 1'b1;
      tag_d[ins_way]   = insert_tag;
      index_d[ins_way] = insert_index;
      data_d[ins_way]  = insert_data;
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q       <= '0;
      s1_valid_q    <= 1'b0;
      s1_index_q    <= '0;
      s1_offset_q   <= '0;
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_byte_q   <= '0;
      resp_block_q  <= '0;
      resp_way_q    <= '0;
      evict_valid_q <= 1'b0;
      evict_tag_q   <= '0;
      evict_index_q <= '0;
      evict_data_q  <= '0;
    end else begin
      valid_q       <= valid_d;
      s1_valid_q    <= s1_valid_d;
      s1_index_q    <= s1_index_d;
      s1_offset_q   <= s1_offset_d;
      resp_valid_q  <= resp_valid_d;
      resp_hit_q    <= resp_hit_d;
      resp_byte_q   <= resp_byte_d;
      resp_block_q  <= resp_block_d;
      resp_way_q    <= resp_way_d;
      evict_valid_q <= evict_valid_d;
      evict_tag_q   <= evict_tag_d;
      evict_index_q <= evict_index_d;
      evict_data_q  <= evict_data_d;
    end
  end

  // Payload storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    tag_q   <= tag_d;
    index_q <= index_d;
    data_q  <= data_d;
  end

  assign resp_valid  = resp_valid_q;
  assign resp_hit    = resp_hit_q;
  assign resp_byte   = resp_byte_q;
  assign resp_block  = resp_block_q;
  assign resp_way    = resp_way_q;
  assign evict_valid = evict_valid_q;
  assign evict_tag   = evict_tag_q;
  assign evict_index = evict_index_q;
  assign evict_data  = evict_data_q;

endmodule
